// File: rtl/memory_board_ctrl.sv
// =============================================================================
// Module   : memory_board_ctrl
// Purpose  : Board/turn controller for an N-cell, multi-player pairs game.
// Revision : 1.0
// =============================================================================
`default_nettype none

module memory_board_ctrl #(
    parameter  int N_CELLS     = 16,
    parameter  int LABEL_W     = 4,
    parameter  int N_PLAYERS   = 2,
    parameter  int SHOW_CYCLES = 4,
    localparam int CW          = $clog2(N_CELLS),
    localparam int PW          = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       move_fwd,
    input  logic                       move_bwd,
    input  logic                       select,
    input  logic                       time_up,
    input  logic [N_CELLS*LABEL_W-1:0] labels,
    output logic [CW-1:0]              cursor,
    output logic [2*N_CELLS-1:0]       cell_state,
    output logic [PW-1:0]              player,
    output logic [N_PLAYERS*8-1:0]     scores,
    output logic [2:0]                 game_state,
    output logic                       match,
    output logic                       mismatch,
    output logic [PW-1:0]              winner,
    output logic                       tie
);

    localparam int SW = $clog2(SHOW_CYCLES + 1);
    localparam int RW = $clog2(N_CELLS / 2 + 1);

    localparam logic [1:0] C_HIDDEN  = 2'b00;
    localparam logic [1:0] C_FACEUP  = 2'b01;
    localparam logic [1:0] C_MATCHED = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK1 = 3'd1,
        ST_PICK2 = 3'd2,
        ST_CHECK = 3'd3,
        ST_SHOW  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cursor_q;
    logic [CW-1:0]        idx1_q;
    logic [CW-1:0]        idx2_q;
    logic [PW-1:0]        player_q;
    logic [PW-1:0]        winner_q;
    logic                 tie_q;
    logic                 match_q;
    logic                 mismatch_q;
    logic [SW-1:0]        cnt_q;
    logic [RW-1:0]        rem_q;
    logic [1:0]           cells_q  [N_CELLS];
    logic [LABEL_W-1:0]   labels_q [N_CELLS];
    logic [7:0]           scores_q [N_PLAYERS];

    logic                 pair_eq;
    logic [7:0]           scores_d [N_PLAYERS];
    logic [7:0]           best_d;
    logic [PW-1:0]        winner_d;
    logic                 tie_d;
    logic [PW-1:0]        player_nxt;
    int                   n_best;

    assign player_nxt = (player_q == PW'(N_PLAYERS - 1)) ? '0 : player_q + 1'b1;

    // Scores as they will be after this cycle's CHECK, so DONE can rank them on entry.
    always_comb begin
        pair_eq  = (labels_q[idx1_q] == labels_q[idx2_q]);
        for (int p = 0; p < N_PLAYERS; p++) begin
            scores_d[p] = scores_q[p];
        end
        if (state_q == ST_CHECK && pair_eq && scores_q[player_q] != 8'hFF) begin
            scores_d[player_q] = scores_q[player_q] + 8'd1;
        end
        best_d   = '0;
        winner_d = '0;
        n_best   = 0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (scores_d[p] > best_d) begin
                best_d   = scores_d[p];
                winner_d = PW'(p);
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (scores_d[p] == best_d) begin
                n_best = n_best + 1;
            end
        end
        tie_d = (n_best > 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cursor_q   <= '0;
            idx1_q     <= '0;
            idx2_q     <= '0;
            player_q   <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            for (int i = 0; i < N_CELLS; i++) begin
                cells_q[i]  <= C_HIDDEN;
                labels_q[i] <= '0;
            end
            for (int p = 0; p < N_PLAYERS; p++) begin
                scores_q[p] <= '0;
            end
        end else begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        for (int i = 0; i < N_CELLS; i++) begin
                            cells_q[i]  <= C_HIDDEN;
                            labels_q[i] <= labels[i*LABEL_W +: LABEL_W];
                        end
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            scores_q[p] <= '0;
                        end
                        player_q <= '0;
                        cursor_q <= '0;
                        winner_q <= '0;
                        tie_q    <= 1'b0;
                        rem_q    <= RW'(N_CELLS / 2);
                        state_q  <= ST_PICK1;
                    end
                end
                ST_PICK1, ST_PICK2: begin
                    // time_up pre-empts select; select always uses the pre-move cursor.
                    if (time_up) begin
                        if (state_q == ST_PICK2) begin
                            cells_q[idx1_q] <= C_HIDDEN;
                        end
                        player_q <= player_nxt;
                        state_q  <= ST_PICK1;
                    end else if (select && cells_q[cursor_q] == C_HIDDEN) begin
                        cells_q[cursor_q] <= C_FACEUP;
                        if (state_q == ST_PICK1) begin
                            idx1_q  <= cursor_q;
                            state_q <= ST_PICK2;
                        end else begin
                            idx2_q  <= cursor_q;
                            state_q <= ST_CHECK;
                        end
                    end
                    if (move_fwd && !move_bwd) begin
                        cursor_q <= (cursor_q == CW'(N_CELLS - 1)) ? '0 : cursor_q + 1'b1;
                    end else if (move_bwd && !move_fwd) begin
                        cursor_q <= (cursor_q == '0) ? CW'(N_CELLS - 1) : cursor_q - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (pair_eq) begin
                        cells_q[idx1_q] <= C_MATCHED;
                        cells_q[idx2_q] <= C_MATCHED;
                        scores_q        <= scores_d;
                        match_q         <= 1'b1;
                        rem_q           <= rem_q - 1'b1;
                        if (rem_q == RW'(1)) begin
                            winner_q <= winner_d;
                            tie_q    <= tie_d;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_PICK1;
                        end
                    end else begin
                        mismatch_q <= 1'b1;
                        cnt_q      <= SW'(SHOW_CYCLES - 1);
                        state_q    <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        cells_q[idx1_q] <= C_HIDDEN;
                        cells_q[idx2_q] <= C_HIDDEN;
                        player_q        <= player_nxt;
                        state_q         <= ST_PICK1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cells
            assign cell_state[2*gi +: 2] = cells_q[gi];
        end
        for (genvar gp = 0; gp < N_PLAYERS; gp++) begin : g_scores
            assign scores[8*gp +: 8] = scores_q[gp];
        end
    endgenerate

    assign cursor     = cursor_q;
    assign player     = player_q;
    assign game_state = state_q;
    assign match      = match_q;
    assign mismatch   = mismatch_q;
    assign winner     = winner_q;
    assign tie        = tie_q;

endmodule

`default_nettype wire
